// File: rtl/mux8_rr_arbiter.sv
// ----------------------------------------------------------------------------
// mux8_rr_arbiter
//
// Round-robin scheduler for a shared 8:1 single-bit mux. Eight requesters
// compete for the mux. The winner owns the select lines for at most MAX_HOLD
// consecutive cycles. The selected data bit is registered onto y.
//
// Parameters
//   MAX_HOLD  maximum consecutive ownership cycles (1..255)
//
// Ports
//   clk    in   1  rising-edge clock
//   rst_n  in   1  asynchronous active-low reset
//   req    in   8  request vector, bit i requests a[i]
//   a      in   8  mux data inputs a0..a7
//   sel    out  3  registered mux select {s2,s1,s0}
//   gnt    out  8  registered one-hot grant, zero when idle
//   busy   out  1  registered "grant active" flag
//   y      out  1  registered mux output, a[sel] while busy, else 0
// ----------------------------------------------------------------------------
module mux8_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic [7:0] a,
    output logic [2:0] sel,
    output logic [7:0] gnt,
    output logic       busy,
    output logic       y
);

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic [2:0] ptr;
    logic [2:0] ptr_nxt;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;
    logic [2:0] sel_nxt;
    logic [7:0] gnt_nxt;
    logic       busy_nxt;
    logic       y_nxt;

    logic [2:0] arb_base;
    logic [2:0] arb_idx;
    logic [2:0] winner;
    logic       found;
    logic       any_req;
    logic       keep_owner;

    // While a grant is active, the search for the next owner already starts
    // one past the current owner; this is the pointer a release would install,
    // so handover and pointer update happen on the same edge.
    assign arb_base   = (state == OWN) ? (sel + 3'd1) : ptr;
    assign any_req    = |req;
    assign keep_owner = req[sel] && (cnt < HOLD_LIMIT);

    // First requesting index at or after arb_base, wrapping modulo 8.
    always_comb begin
        winner  = arb_base;
        found   = 1'b0;
        arb_idx = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            arb_idx = arb_base + 3'(k);
            if (!found && req[arb_idx]) begin
                winner = arb_idx;
                found  = 1'b1;
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        sel_nxt   = sel;
        gnt_nxt   = gnt;

        unique case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = OWN;
                    sel_nxt   = winner;
                    gnt_nxt   = 8'(1) << winner;
                    cnt_nxt   = 8'd1;
                end
            end

            OWN: begin
                if (keep_owner) begin
                    cnt_nxt = cnt + 8'd1;
                end else begin
                    // Release: pointer moves past the owner; the previous
                    // owner is reachable only as the last candidate.
                    ptr_nxt = sel + 3'd1;
                    if (any_req) begin
                        sel_nxt = winner;
                        gnt_nxt = 8'(1) << winner;
                        cnt_nxt = 8'd1;
                    end else begin
                        state_nxt = IDLE;
                        gnt_nxt   = '0;
                        cnt_nxt   = '0;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                cnt_nxt   = '0;
            end
        endcase

        busy_nxt = (state_nxt == OWN);
        y_nxt    = busy ? a[sel] : 1'b0;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            cnt   <= '0;
            sel   <= '0;
            gnt   <= '0;
            busy  <= 1'b0;
            y     <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
            sel   <= sel_nxt;
            gnt   <= gnt_nxt;
            busy  <= busy_nxt;
            y     <= y_nxt;
        end
    end

endmodule
